// File: rtl/axis_deadlock_monitor_param.sv
// Deadlock monitor for AXIS streaming kernels: qualifies a persistent all-stalled
// condition over TIMEOUT cycles and latches a sticky report for software to read.
module axis_deadlock_monitor_param #(
    parameter int N_AXIS  = 4,
    parameter int N_INST  = 3,
    parameter int TIMEOUT = 16,
    parameter int EVT_W   = 8,
    localparam int IDX_W  = (N_AXIS > 1) ? $clog2(N_AXIS) : 1
) (
    input  logic              kernel_monitor_clock,
    input  logic              kernel_monitor_reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_pulse,
    output logic              block_sticky,
    output logic [N_AXIS-1:0] blk_snapshot,
    output logic [IDX_W-1:0]  first_idx,
    output logic [EVT_W-1:0]  event_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, BLOCKED} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               blockPulse_q;
    logic               blockSticky_q, blockSticky_d;
    logic [N_AXIS-1:0]  blkSnapshot_q, blkSnapshot_d;
    logic [IDX_W-1:0]   firstIdx_q, firstIdx_d;
    logic [EVT_W-1:0]   eventCount_q, eventCount_d;
    logic [EVT_W-1:0]   eventBase;
    logic [IDX_W-1:0]   lowIdx;
    logic               candidate;
    logic               enterBlocked;

    // A fully idle system is quiescent, not deadlocked, so it is excluded.
    always_comb begin
        candidate = (&(inst_idle_sigs | inst_block_sigs)) & (|axis_block_sigs) & ~(&inst_idle_sigs);
    end

    always_comb begin
        lowIdx = '0;
        for (int k = N_AXIS - 1; k >= 0; k--) begin
            if (axis_block_sigs[k]) begin
                lowIdx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enterBlocked = 1'b0;
        case (state_q)
            IDLE: begin
                if (candidate) begin
                    if (TIMEOUT == 1) begin
                        state_d      = BLOCKED;
                        enterBlocked = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        state_d = ARMED;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ARMED: begin
                if (!candidate) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = BLOCKED;
                    enterBlocked = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BLOCKED: begin
                if (!candidate) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Clear is applied first so that a simultaneous entry overrides it.
    always_comb begin
        eventBase     = clear ? '0 : eventCount_q;
        blockSticky_d = clear ? 1'b0 : blockSticky_q;
        blkSnapshot_d = clear ? '0 : blkSnapshot_q;
        firstIdx_d    = clear ? '0 : firstIdx_q;
        eventCount_d  = eventBase;
        if (enterBlocked) begin
            blockSticky_d = 1'b1;
            blkSnapshot_d = axis_block_sigs;
            firstIdx_d    = lowIdx;
            eventCount_d  = (eventBase == EVT_MAX) ? eventBase : eventBase + EVT_W'(1);
        end
    end

    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            blockPulse_q  <= 1'b0;
            blockSticky_q <= 1'b0;
            blkSnapshot_q <= '0;
            firstIdx_q    <= '0;
            eventCount_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            blockPulse_q  <= enterBlocked;
            blockSticky_q <= blockSticky_d;
            blkSnapshot_q <= blkSnapshot_d;
            firstIdx_q    <= firstIdx_d;
            eventCount_q  <= eventCount_d;
        end
    end

    assign block        = (state_q == BLOCKED);
    assign block_pulse  = blockPulse_q;
    assign block_sticky = blockSticky_q;
    assign blk_snapshot = blkSnapshot_q;
    assign first_idx    = firstIdx_q;
    assign event_count  = eventCount_q;

endmodule

// File: tb/tb_axis_deadlock_monitor_param.sv
// Directed bench for axis_deadlock_monitor_param with TIMEOUT=8: a per-cycle vector
// table plus hand-written sequences for restart, all-idle, saturation and clear-on-entry.
module tb_axis_deadlock_monitor_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [3:0] axis;
    logic [2:0] idle;
    logic [2:0] iblk;
    logic       block;
    logic       blockPulse;
    logic       blockSticky;
    logic [3:0] blkSnapshot;
    logic [1:0] firstIdx;
    logic [7:0] eventCount;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic       rst;
        logic       clr;
        logic [3:0] axis;
        logic [2:0] idle;
        logic [2:0] iblk;
        logic       eBlock;
        logic       ePulse;
        logic       eSticky;
        logic [3:0] eSnap;
        logic [1:0] eIdx;
        logic [7:0] eEvt;
    } vec_t;

    vec_t vecs[$];

    axis_deadlock_monitor_param #(
        .N_AXIS(4), .N_INST(3), .TIMEOUT(8), .EVT_W(8)
    ) dut (
        .kernel_monitor_clock(clk),
        .kernel_monitor_reset(rst),
        .axis_block_sigs(axis),
        .inst_idle_sigs(idle),
        .inst_block_sigs(iblk),
        .clear(clr),
        .block(block),
        .block_pulse(blockPulse),
        .block_sticky(blockSticky),
        .blk_snapshot(blkSnapshot),
        .first_idx(firstIdx),
        .event_count(eventCount)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic r, input logic c, input logic [3:0] a,
                                 input logic [2:0] id, input logic [2:0] ib);
        rst  = r;
        clr  = c;
        axis = a;
        idle = id;
        iblk = ib;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eB, input logic eP, input logic eS,
                            input logic [3:0] eSn, input logic [1:0] eI, input logic [7:0] eE);
        checkOutput({tag, " block"},        {7'd0, block},       {7'd0, eB});
        checkOutput({tag, " block_pulse"},  {7'd0, blockPulse},  {7'd0, eP});
        checkOutput({tag, " block_sticky"}, {7'd0, blockSticky}, {7'd0, eS});
        checkOutput({tag, " blk_snapshot"}, {4'd0, blkSnapshot}, {4'd0, eSn});
        checkOutput({tag, " first_idx"},    {6'd0, firstIdx},    {6'd0, eI});
        checkOutput({tag, " event_count"},  eventCount,          eE);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 4'b0000, 3'b000, 3'b000);
        step();
        step();
        applyStimulus(1'b0, 1'b0, 4'b0000, 3'b000, 3'b000);
    endtask

    task automatic addVec(input logic r, input logic c, input logic [3:0] a, input logic [2:0] id,
                          input logic [2:0] ib, input logic eB, input logic eP, input logic eS,
                          input logic [3:0] eSn, input logic [1:0] eI, input logic [7:0] eE);
        vec_t v;
        v.rst = r;  v.clr = c;  v.axis = a;  v.idle = id;  v.iblk = ib;
        v.eBlock = eB;  v.ePulse = eP;  v.eSticky = eS;
        v.eSnap = eSn;  v.eIdx = eI;  v.eEvt = eE;
        vecs.push_back(v);
    endtask

    // Each vector holds the inputs for one cycle and the outputs expected during it.
    initial begin
        for (int i = 0; i < 8; i++)
            addVec(0, 0, 4'b0100, 3'b010, 3'b101, 0, 0, 0, 4'b0000, 2'd0, 8'd0);
        addVec(0, 0, 4'b0100, 3'b010, 3'b101, 1, 1, 1, 4'b0100, 2'd2, 8'd1);
        addVec(0, 0, 4'b0100, 3'b010, 3'b101, 1, 0, 1, 4'b0100, 2'd2, 8'd1);
        addVec(0, 0, 4'b0000, 3'b010, 3'b101, 1, 0, 1, 4'b0100, 2'd2, 8'd1);
        addVec(0, 1, 4'b0000, 3'b010, 3'b101, 0, 0, 1, 4'b0100, 2'd2, 8'd1);
        for (int i = 12; i < 20; i++)
            addVec(0, 0, (i == 15) ? 4'b0001 : 4'b1010, 3'b010, 3'b101, 0, 0, 0, 4'b0000, 2'd0, 8'd0);
        addVec(0, 0, 4'b0100, 3'b010, 3'b101, 1, 1, 1, 4'b1010, 2'd1, 8'd1);
        addVec(1, 0, 4'b0100, 3'b010, 3'b101, 1, 0, 1, 4'b1010, 2'd1, 8'd1);
        addVec(0, 0, 4'b0000, 3'b000, 3'b000, 0, 0, 0, 4'b0000, 2'd0, 8'd0);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            checkAll($sformatf("vec%0d", i), vecs[i].eBlock, vecs[i].ePulse, vecs[i].eSticky,
                     vecs[i].eSnap, vecs[i].eIdx, vecs[i].eEvt);
            applyStimulus(vecs[i].rst, vecs[i].clr, vecs[i].axis, vecs[i].idle, vecs[i].iblk);
            step();
        end

        // One non-candidate cycle inside ARMED must restart the qualification window.
        $display("[TB] restart after drop");
        doReset();
        for (int c = 0; c <= 14; c++) begin
            checkOutput($sformatf("restart c%0d block", c), {7'd0, block}, {7'd0, (c == 14)});
            applyStimulus(0, 0, (c == 5) ? 4'b0000 : 4'b0100, 3'b010, 3'b101);
            step();
        end
        checkOutput("restart event_count", eventCount, 8'd1);

        $display("[TB] all instances idle");
        doReset();
        for (int c = 0; c < 50; c++) begin
            applyStimulus(0, 0, 4'b1111, 3'b111, 3'b000);
            step();
            checkOutput($sformatf("allidle c%0d block", c), {7'd0, block}, 8'd0);
        end
        checkOutput("allidle event_count", eventCount, 8'd0);
        checkOutput("allidle block_sticky", {7'd0, blockSticky}, 8'd0);

        $display("[TB] event counter saturation");
        doReset();
        for (int r = 1; r <= 300; r++) begin
            for (int c = 0; c < 8; c++) begin
                applyStimulus(0, 0, 4'b0100, 3'b010, 3'b101);
                step();
            end
            applyStimulus(0, 0, 4'b0000, 3'b010, 3'b101);
            step();
            step();
            checkOutput($sformatf("sat round%0d event_count", r), eventCount,
                        (r > 255) ? 8'd255 : 8'(r));
        end

        // Counter is saturated and sticky set, so a clear that lost would be visible.
        $display("[TB] clear on entry cycle");
        for (int c = 0; c < 7; c++) begin
            applyStimulus(0, 0, 4'b0100, 3'b010, 3'b101);
            step();
        end
        applyStimulus(0, 1, 4'b0100, 3'b010, 3'b101);
        step();
        checkAll("clr-entry", 1, 1, 1, 4'b0100, 2'd2, 8'd1);
        applyStimulus(0, 0, 4'b0000, 3'b010, 3'b101);
        step();
        checkAll("clr-entry+1", 0, 0, 1, 4'b0100, 2'd2, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/axis_deadlock_monitor_param.md
Name: axis_deadlock_monitor_param

Overview:
- Parametrised successor to the per-kernel deadlock detector used in co-simulation and on-board debug for the OFDM streaming kernels (pixl2sym and siblings).
- Aggregates N_AXIS stream-blocked flags and N_INST per-instance idle/blocked flags, and qualifies a deadlock only after it persists for TIMEOUT consecutive cycles.
- Latches a sticky flag, a snapshot of the blocked channels, the lowest blocked channel index, and a saturating event count. Software or the testbench reads these instead of relying on a display message.

Parameters:
- N_AXIS, 4, number of AXIS blocked-flag inputs (1..64)
- N_INST, 3, number of monitored instances (1..32)
- TIMEOUT, 16, consecutive candidate cycles required before declaring deadlock (1..65535)
- EVT_W, 8, width of saturating deadlock-event counter

Ports:
- kernel_monitor_clock  in  1  clock; all logic on rising edge
- kernel_monitor_reset  in  1  synchronous active-high reset
- axis_block_sigs  in  N_AXIS  1 = channel k stalled on TDATA handshake
- inst_idle_sigs  in  N_INST  1 = instance i ap_idle
- inst_block_sigs  in  N_INST  1 = instance i blocked internally
- clear  in  1  synchronous clear of sticky/report state
- block  out  1  deadlock currently qualified
- block_pulse  out  1  one-cycle pulse on entry to BLOCKED
- block_sticky  out  1  set on detection, held until clear/reset
- blk_snapshot  out  N_AXIS  axis_block_sigs captured on entry to BLOCKED
- first_idx  out  clog2(N_AXIS) (min 1)  lowest set bit of snapshot
- event_count  out  EVT_W  number of BLOCKED entries, saturating

Behaviour:
- Reset: every output is 0, FSM enters IDLE, and the counter is 0.
- stalled_i = inst_idle_sigs[i] | inst_block_sigs[i].
- candidate = (&stalled) & (|axis_block_sigs) & ~(&inst_idle_sigs), evaluated on registered-free inputs in the same cycle.
  - All instances idle is never a deadlock.
  - No AXIS blocked is never a deadlock.
- Counter cnt has width clog2(TIMEOUT+1).
- FSM states: IDLE, ARMED, BLOCKED.
  - IDLE: if candidate, go to ARMED with cnt=1; if TIMEOUT==1, go directly to BLOCKED.
  - ARMED:
    - If candidate is low, go to IDLE and set cnt=0.
    - Otherwise, if cnt==TIMEOUT-1, go to BLOCKED.
    - Otherwise, increment cnt.
  - BLOCKED: stay while candidate is high. When candidate drops, go to IDLE (cnt=0) and deassert block the next cycle.
- block is a registered output: high exactly while the FSM is in BLOCKED. Latency from the first candidate cycle to block=1 is TIMEOUT cycles.
- On the transition into BLOCKED, all of the following take effect in the same edge:
  - block_pulse=1 for one cycle
  - block_sticky set to 1
  - blk_snapshot and first_idx loaded from axis_block_sigs sampled in that cycle
  - event_count incremented, saturating at 2^EVT_W-1
- The snapshot is not updated while the FSM remains in BLOCKED.
- clear:
  - Zeroes block_sticky, blk_snapshot, first_idx and event_count.
  - Does not affect FSM, cnt or block.
  - If clear coincides with an entry into BLOCKED, the entry wins: sticky=1, snapshot loaded, event_count=1.
- Reset asserted mid-operation, including in BLOCKED, forces everything to the reset state next edge. No pulse is generated.
- Flag changes during ARMED (a different channel blocked but candidate still high) do not restart the count.
- Re-entry after a drop increments event_count again and overwrites the snapshot.
- No combinational path from inputs to outputs.

Test Plan (N_AXIS=4, N_INST=3, TIMEOUT=8, EVT_W=8):
- Hold idle=3'b010, inst_block=3'b101, axis=4'b0100 from cycle 0:
  - block=0 through cycle 7; block=1 and block_pulse=1 at cycle 8 (pulse low at cycle 9)
  - block_sticky=1, blk_snapshot=4'b0100, first_idx=2, event_count=1
- Same stimulus, but candidate drops at cycle 5 (axis=0) and resumes at cycle 6 -> block=1 only at cycle 14, confirming the count restarted.
- Inputs idle=3'b111, axis=4'b1111 for 50 cycles -> block stays 0 and event_count stays 0.
- After detection, drop candidate -> block=0 the next cycle with sticky still 1.
  - Pulse clear -> sticky=0, snapshot=0, event_count=0.
  - Re-trigger with axis=4'b1010 -> first_idx=1, event_count=1.
- Drive 300 detect/release cycles -> event_count saturates at 255.
- Assert reset in BLOCKED -> all outputs 0 next edge.
- Assert clear on the exact entry cycle -> sticky=1, event_count=1.
